// File: rtl/pc_fetch_pkg.sv
// Shared types and defaults for the fetch sequencer: state encoding, word width,
// reset/trap vectors and the sequential PC step.
package pc_fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEF_TRAP_VEC = 32'h0000_0080;
    localparam logic [XLEN-1:0] DEF_PC_STEP  = 32'd4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_HALT = 3'd4
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_buffer.sv
// One-entry instruction buffer toward decode; a load fills it, a decode
// handshake or a flush empties it. Data is retained after the entry is emptied.
module pc_inst_buffer
    import pc_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [XLEN-1:0] load_inst,
    input  logic [XLEN-1:0] load_pc,
    input  logic            flush,
    input  logic            inst_ready,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] ipc_q, ipc_d;

    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        ipc_d   = ipc_q;
        if (load) begin
            valid_d = 1'b1;
            inst_d  = load_inst;
            ipc_d   = load_pc;
        end else if (flush || (valid_q && inst_ready)) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            ipc_q   <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            ipc_q   <= ipc_d;
        end
    end

    assign inst_valid = valid_q;
    assign inst       = inst_q;
    assign inst_pc    = ipc_q;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC owner and single-outstanding fetch sequencer with redirect/kill handling.
// Optional macro PC_FETCH_MISALIGN_TRAP_EN: misaligned redirects vector to TRAP_VEC.
//
// state  | meaning
// S_IDLE | first cycle after reset
// S_REQ  | request valid toward imem, waiting for ready
// S_WAIT | request accepted, waiting for response (kill drops it)
// S_HOLD | instruction buffered, waiting for decode
// S_HALT | halt held, no requests
module pc_fetch_sequencer
    import pc_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
    parameter logic [XLEN-1:0] TRAP_VEC = DEF_TRAP_VEC,
    parameter logic [XLEN-1:0] PC_STEP  = DEF_PC_STEP
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            halt,
    output logic [XLEN-1:0] pc,
    output logic            halted,
    output logic            misalign
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] issued_q, issued_d;
    logic            kill_q, kill_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] redir_pc;
    logic            redir_bad;
    logic            buf_load, buf_flush;

`ifdef PC_FETCH_MISALIGN_TRAP_EN
    assign redir_bad = (redirect_target[1:0] != 2'b00);
    assign redir_pc  = redir_bad ? TRAP_VEC : redirect_target;
`else
    logic unused_trap_bits;
    assign unused_trap_bits = ^{TRAP_VEC, redirect_target[1:0]};
    assign redir_bad        = 1'b0;
    assign redir_pc         = align_word(redirect_target);
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        issued_d   = issued_q;
        kill_d     = kill_q;
        buf_load   = 1'b0;
        buf_flush  = 1'b0;
        misalign_d = redirect_valid && redir_bad;
        if (redirect_valid) pc_d = redir_pc;

        case (state_q)
            S_IDLE: state_d = halt ? S_HALT : S_REQ;
            S_REQ: begin
                if (imem_req_ready) begin
                    // The old address is already on the bus; a same-cycle redirect kills its response.
                    issued_d = pc_q;
                    kill_d   = redirect_valid;
                    state_d  = S_WAIT;
                end else if (!redirect_valid && halt) begin
                    state_d = S_HALT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    kill_d = 1'b0;
                    if (redirect_valid) begin
                        state_d = S_REQ;
                    end else if (kill_q) begin
                        state_d = halt ? S_HALT : S_REQ;
                    end else begin
                        buf_load = 1'b1;
                        pc_d     = pc_q + PC_STEP;
                        state_d  = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    buf_flush = 1'b1;
                    state_d   = S_REQ;
                end else if (inst_ready) begin
                    state_d = halt ? S_HALT : S_REQ;
                end
            end
            S_HALT: if (!halt) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            issued_q   <= '0;
            kill_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            issued_q   <= issued_d;
            kill_q     <= kill_d;
            misalign_q <= misalign_d;
        end
    end

    pc_inst_buffer u_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .load_inst (imem_rsp_data),
        .load_pc   (issued_q),
        .flush     (buf_flush),
        .inst_ready(inst_ready),
        .inst_valid(inst_valid),
        .inst      (inst),
        .inst_pc   (inst_pc)
    );

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_addr      = pc_q;
    assign pc             = pc_q;
    assign halted         = (state_q == S_HALT);
    assign misalign       = misalign_q;

endmodule
